// File: rtl/fact_pkg.sv
// -----------------------------------------------------------------------------
// fact_pkg
// Shared types and constants for the factorial coprocessor.
//   state_t  : controller state encoding (2 bits)
//   PROD_W   : partial-product width for the default configuration
//   prod_w() : partial-product width for any DATA_W/N_W pairing
//   ONE      : accumulator seed value
// -----------------------------------------------------------------------------
package fact_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        CHECK = 2'd1,
        MUL   = 2'd2,
        DONE  = 2'd3
    } state_t;

    localparam int DEF_DATA_W = 32;
    localparam int DEF_N_W    = 8;
    localparam int PROD_W     = DEF_DATA_W + DEF_N_W;

    localparam logic ONE = 1'b1;

    function automatic int prod_w(input int data_w, input int n_w);
        return data_w + n_w;
    endfunction

endpackage

// File: rtl/factorial_engine_if.sv
// -----------------------------------------------------------------------------
// factorial_engine_if
// Core-side request/response bundle of the factorial coprocessor.
//   start    : request (core -> engine)
//   n        : operand, N_W bits (core -> engine)
//   busy     : operation in progress (engine -> core)
//   done     : one-cycle completion pulse (engine -> core)
//   result   : n! (mod 2^DATA_W, or saturated), DATA_W bits (engine -> core)
//   overflow : true n! did not fit in DATA_W bits (engine -> core)
// Modports: master = core side, slave = engine side.
// -----------------------------------------------------------------------------
interface factorial_engine_if #(
    parameter int DATA_W = 32,
    parameter int N_W    = 8
);
    logic              start;
    logic [N_W-1:0]    n;
    logic              busy;
    logic              done;
    logic [DATA_W-1:0] result;
    logic              overflow;

    modport master (
        output start, n,
        input  busy, done, result, overflow
    );

    modport slave (
        input  start, n,
        output busy, done, result, overflow
    );
endinterface

// File: rtl/factorial_engine_seq_mul.sv
// -----------------------------------------------------------------------------
// seq_mul
// Sequential shift-add multiplier: DATA_W x N_W -> DATA_W+N_W bits, one bit of
// b per cycle, N_W cycles per product.
//   clk, rst : clock / async active-high reset (clears only the run flag)
//   go       : load a and b and start a product
//   a, b     : multiplicand (DATA_W) and multiplier (N_W)
//   valid    : high during the N_W-th cycle after go
//   prod     : final product, meaningful while valid is high
// -----------------------------------------------------------------------------
module seq_mul
    import fact_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int N_W    = 8
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic                              go,
    input  logic [DATA_W-1:0]                 a,
    input  logic [N_W-1:0]                    b,
    output logic                              valid,
    output logic [prod_w(DATA_W, N_W)-1:0]    prod
);
    localparam int PW = prod_w(DATA_W, N_W);
    localparam int CW = $clog2(N_W + 1);

    logic          run;
    logic [CW-1:0] k;
    logic [PW-1:0] a_r;
    logic [PW-1:0] p_r;
    logic [N_W-1:0] b_r;
    logic [PW-1:0] p_nxt;

    // The product leaves through p_nxt so the caller can capture it on the
    // same edge that performs the final add step.
    assign p_nxt = p_r + (b_r[0] ? a_r : '0);
    assign prod  = p_nxt;
    assign valid = run && (k == CW'(N_W - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst)        run <= 1'b0;
        else if (go)    run <= 1'b1;
        else if (valid) run <= 1'b0;
    end

    always_ff @(posedge clk) begin
        if (go) begin
            a_r <= PW'(a);
            b_r <= b;
            p_r <= '0;
            k   <= '0;
        end else if (run) begin
            a_r <= a_r << 1;
            b_r <= b_r >> 1;
            p_r <= p_nxt;
            k   <= k + CW'(1);
        end
    end

endmodule

// File: rtl/factorial_engine.sv
// -----------------------------------------------------------------------------
// factorial_engine
// Iterative n! coprocessor. Accepts start in IDLE, then alternates CHECK and
// an N_W-cycle MUL until the down-counter reaches 1, then pulses done.
//   clk1 : sole clock, rising edge
//   rst  : asynchronous, active-high reset
//   bus  : factorial_engine_if.slave (start, n in; busy, done, result,
//          overflow out -- all outputs registered)
// Build option: define FACT_SAT_EN to load all-ones into result whenever
// overflow is set; otherwise result is n! mod 2^DATA_W.
// -----------------------------------------------------------------------------
module factorial_engine
    import fact_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int N_W    = DEF_N_W
) (
    input  logic                clk1,
    input  logic                rst,
    factorial_engine_if.slave   bus
);
    localparam int PW = prod_w(DATA_W, N_W);

    state_t            state;
    state_t            state_nxt;
    logic [N_W-1:0]    cnt;
    logic [DATA_W-1:0] acc;
    logic              ovf;

    logic              mul_go;
    logic              mul_valid;
    logic [PW-1:0]     mul_prod;

    logic              busy_r;
    logic              done_r;
    logic [DATA_W-1:0] result_r;
    logic              overflow_r;

    function automatic logic [DATA_W-1:0] sat_result(
        input logic [DATA_W-1:0] value,
        input logic              sat
    );
        return sat ? {DATA_W{1'b1}} : value;
    endfunction

    seq_mul #(
        .DATA_W (DATA_W),
        .N_W    (N_W)
    ) u_mul (
        .clk   (clk1),
        .rst   (rst),
        .go    (mul_go),
        .a     (acc),
        .b     (cnt),
        .valid (mul_valid),
        .prod  (mul_prod)
    );

    always_comb begin
        state_nxt = state;
        mul_go    = 1'b0;
        case (state)
            IDLE:  if (bus.start) state_nxt = CHECK;
            CHECK: begin
                if (cnt <= N_W'(1)) begin
                    state_nxt = DONE;
                end else begin
                    mul_go    = 1'b1;
                    state_nxt = MUL;
                end
            end
            MUL:   if (mul_valid) state_nxt = CHECK;
            DONE:  state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk1 or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    // cnt only decrements after a multiply, and a multiply is only launched
    // from cnt >= 2, so the counter never wraps.
    always_ff @(posedge clk1) begin
        if (state == IDLE && bus.start) begin
            cnt <= bus.n;
            acc <= DATA_W'(ONE);
            ovf <= 1'b0;
        end else if (state == MUL && mul_valid) begin
            acc <= mul_prod[DATA_W-1:0];
            ovf <= ovf | (|mul_prod[PW-1:DATA_W]);
            cnt <= cnt - N_W'(1);
        end
    end

    // Outputs are decoded from the next state so they line up with the state
    // register; result/overflow only move on DONE entry.
    always_ff @(posedge clk1 or posedge rst) begin
        if (rst) begin
            busy_r     <= 1'b0;
            done_r     <= 1'b0;
            result_r   <= '0;
            overflow_r <= 1'b0;
        end else begin
            busy_r <= (state_nxt == CHECK) || (state_nxt == MUL);
            done_r <= (state_nxt == DONE);
            if (state_nxt == DONE) begin
                overflow_r <= ovf;
`ifdef FACT_SAT_EN
                result_r   <= sat_result(acc, ovf);
`else
                result_r   <= acc;
`endif
            end
        end
    end

    assign bus.busy     = busy_r;
    assign bus.done     = done_r;
    assign bus.result   = result_r;
    assign bus.overflow = overflow_r;

endmodule

// File: tb/tb_factorial_engine.sv
// Scoreboard bench for factorial_engine: two instances (32/8 and 64/5),
// expected responses queued at issue time and checked by per-DUT monitors.
module tb_factorial_engine;

    logic clk1 = 1'b0;
    logic rst  = 1'b1;
    always #5 clk1 = ~clk1;

    factorial_engine_if #(.DATA_W(32), .N_W(8)) bus_a ();
    factorial_engine_if #(.DATA_W(64), .N_W(5)) bus_b ();

    factorial_engine #(.DATA_W(32), .N_W(8)) dut_a (
        .clk1 (clk1),
        .rst  (rst),
        .bus  (bus_a)
    );

    factorial_engine #(.DATA_W(64), .N_W(5)) dut_b (
        .clk1 (clk1),
        .rst  (rst),
        .bus  (bus_b)
    );

    typedef struct {
        logic [63:0] res;
        bit          ovf;
        int          lat;
        int          acc;
    } exp_t;

    exp_t        q [2][$];
    logic [63:0] last_res [2];
    int          cyc   = 0;
    int          tests = 0;
    int          fails = 0;

    always @(posedge clk1) cyc++;

    // Reference: exact factorial tracked modulo 2^dw with a sticky flag raised
    // the first time the true value no longer fits in dw bits.
    function automatic void model(input int dw, input int nw, input int n,
                                  output logic [63:0] r, output bit ov,
                                  output int lat);
        logic [127:0] a;
        logic [127:0] full;
        logic [127:0] mask;
        a    = 128'd1;
        mask = (128'd1 << dw) - 128'd1;
        ov   = 1'b0;
        for (int i = 2; i <= n; i++) begin
            full = a * 128'(i);
            if ((full >> dw) != 128'd0) ov = 1'b1;
            a = full & mask;
        end
        r = a[63:0];
`ifdef FACT_SAT_EN
        if (ov) r = mask[63:0];
`endif
        lat = ((n > 1 ? n : 1) - 1) * (nw + 1) + 1;
    endfunction

    task automatic cmp(input string nm, input int d,
                       input logic [63:0] got, input logic [63:0] want);
        tests++;
        if (got !== want) begin
            fails++;
            $display("FAIL %s dut%0d: got %0d, expected %0d", nm, d, got, want);
        end
    endtask

    task automatic drive(input int d, input logic s, input int n);
        if (d == 0) begin
            bus_a.start = s;
            bus_a.n     = 8'(n);
        end else begin
            bus_b.start = s;
            bus_b.n     = 5'(n);
        end
    endtask

    task automatic check(input int d, input logic done, input logic busy,
                         input logic [63:0] res, input logic ovf);
        exp_t e;
        logic exp_busy;
        if (done) begin
            if (q[d].size() == 0) begin
                cmp("unexpected_done", d, 64'(done), 64'd0);
            end else begin
                e = q[d].pop_front();
                cmp("result",       d, res,              e.res);
                cmp("overflow",     d, 64'(ovf),         64'(e.ovf));
                cmp("latency",      d, 64'(cyc - e.acc), 64'(e.lat));
                cmp("busy_at_done", d, 64'(busy),        64'd0);
            end
            last_res[d] = res;
        end else begin
            exp_busy = (q[d].size() > 0) && (q[d][0].acc <= cyc);
            cmp("busy", d, 64'(busy), 64'(exp_busy));
            if (busy) cmp("result_hold", d, res, last_res[d]);
        end
    endtask

    always @(posedge clk1) begin
        #1;
        check(0, bus_a.done, bus_a.busy, 64'(bus_a.result), bus_a.overflow);
    end

    always @(posedge clk1) begin
        #1;
        check(1, bus_b.done, bus_b.busy, bus_b.result, bus_b.overflow);
    end

    task automatic issue(input int d, input int n);
        exp_t e;
        @(negedge clk1);
        model(d ? 64 : 32, d ? 5 : 8, n, e.res, e.ovf, e.lat);
        e.acc = cyc + 1;
        q[d].push_back(e);
        drive(d, 1'b1, n);
        @(negedge clk1);
        drive(d, 1'b0, int'($urandom));
    endtask

    task automatic wait_empty(input int d, input int bound);
        int i;
        for (i = 0; i < bound; i++) begin
            if (q[d].size() == 0) break;
            @(negedge clk1);
        end
        cmp("done_timeout", d, 64'(i < bound), 64'd1);
        if (i >= bound) q[d].delete();
    endtask

    task automatic run(input int d, input int n);
        issue(d, n);
        wait_empty(d, 3000);
        @(negedge clk1);
    endtask

    initial begin
        last_res[0] = '0;
        last_res[1] = '0;
        drive(0, 1'b0, 0);
        drive(1, 1'b0, 0);
        rst = 1'b1;
        repeat (3) @(negedge clk1);
        cmp("rst_busy",     0, 64'(bus_a.busy),     64'd0);
        cmp("rst_done",     0, 64'(bus_a.done),     64'd0);
        cmp("rst_result",   0, 64'(bus_a.result),   64'd0);
        cmp("rst_overflow", 0, 64'(bus_a.overflow), 64'd0);
        cmp("rst_busy",     1, 64'(bus_b.busy),     64'd0);
        cmp("rst_result",   1, bus_b.result,        64'd0);
        rst = 1'b0;
        repeat (2) @(negedge clk1);

        // n=5 with stray starts mid-MUL and during DONE; neither may launch.
        issue(0, 5);
        repeat (10) @(negedge clk1);
        drive(0, 1'b1, 9);
        @(negedge clk1);
        drive(0, 1'b0, 0);
        wait_empty(0, 200);
        drive(0, 1'b1, 9);
        @(negedge clk1);
        drive(0, 1'b0, 0);
        repeat (40) @(negedge clk1);
        run(0, 3);

        // Asynchronous reset in the middle of n=7.
        issue(0, 7);
        repeat (15) @(negedge clk1);
        #2;
        rst = 1'b1;
        q[0].delete();
        q[1].delete();
        last_res[0] = '0;
        last_res[1] = '0;
        #1;
        cmp("arst_busy",     0, 64'(bus_a.busy),     64'd0);
        cmp("arst_done",     0, 64'(bus_a.done),     64'd0);
        cmp("arst_result",   0, 64'(bus_a.result),   64'd0);
        cmp("arst_overflow", 0, 64'(bus_a.overflow), 64'd0);
        @(negedge clk1);
        rst = 1'b0;
        repeat (2) @(negedge clk1);
        run(0, 4);

        run(0, 0);
        run(0, 1);
        run(0, 12);
        run(0, 13);

        run(1, 20);
        run(1, 0);
        run(1, 1);
        for (int i = 0; i < 4; i++) run(1, int'($urandom_range(0, 31)));

        for (int i = 0; i < 15; i++) run(0, int'($urandom_range(0, 40)));
        for (int i = 0; i < 2; i++)  run(0, int'($urandom_range(0, 255)));

        repeat (5) @(negedge clk1);
        cmp("queue_drained", 0, 64'(q[0].size()), 64'd0);
        cmp("queue_drained", 1, 64'(q[1].size()), 64'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
